// File: rtl/simple_circuit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_circuit_pkg
// Brief    : Default sizing and stage-1 record for the simple_circuit pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package simple_circuit_pkg;

   localparam int SC_WIDTH  = 8;
   localparam int SC_CNT_W  = 16;
   localparam int SC_THRESH = 4;

   // Stage-1 record at the default operand width.
   typedef struct packed {
      logic [SC_WIDTH-1:0] and_out;
      logic [SC_WIDTH-1:0] or_out;
      logic [SC_WIDTH-1:0] inv_out;
      logic [SC_WIDTH-1:0] c;
   } sc_s1_t;

endpackage
`default_nettype wire

// File: rtl/simple_circuit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : simple_circuit_pipe_if
// Brief    : Operand/result handshake bus plus activity-monitor signals.
// Revision : 1.0 - initial release
// ============================================================================
interface simple_circuit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] h;
   logic [WIDTH-1:0] int1;
   logic [WIDTH-1:0] int2;
   logic             out_valid;
   logic             out_ready;
   logic             clr_cnt;
   logic [CNT_W-1:0] rare_cnt;
   logic             alert;

   modport master (
      output a, b, c, in_valid, out_ready, clr_cnt,
      input  in_ready, e, f, g, h, int1, int2, out_valid, rare_cnt, alert
   );

   modport slave (
      input  a, b, c, in_valid, out_ready, clr_cnt,
      output in_ready, e, f, g, h, int1, int2, out_valid, rare_cnt, alert
   );
endinterface
`default_nettype wire

// File: rtl/sc_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module   : sc_pipe_slice
// Brief    : Single-entry valid/ready register slice; optional data reset.
// Revision : 1.0 - initial release
// ============================================================================
module sc_pipe_slice #(
   parameter int DW         = 8,
   parameter bit RESET_DATA = 1'b0
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          i_valid,
   output logic               o_ready,
   input  wire logic [DW-1:0] i_data,
   output logic               o_valid,
   input  wire logic          i_ready,
   output logic [DW-1:0]      o_data
);
   logic          r_valid;
   logic [DW-1:0] r_data;
   logic          w_load;

   // Loading into an empty slot never depends on the downstream ready.
   assign w_load  = !r_valid || i_ready;
   assign o_ready = w_load;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= i_valid;
      end
   end

   generate
      if (RESET_DATA) begin : g_rst_data
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_data <= '0;
            end else if (w_load && i_valid) begin
               r_data <= i_data;
            end
         end
      end else begin : g_plain_data
         always_ff @(posedge clk) begin
            if (w_load && i_valid) begin
               r_data <= i_data;
            end
         end
      end
   endgenerate
endmodule
`default_nettype wire

// File: rtl/simple_circuit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : simple_circuit_pipe
// Brief    : Two-stage bitwise simple_circuit with H-activity counter and alert.
// Revision : 1.0 - initial release
// ============================================================================
module simple_circuit_pipe
   import simple_circuit_pkg::*;
#(
   parameter int WIDTH  = SC_WIDTH,
   parameter int CNT_W  = SC_CNT_W,
   parameter int THRESH = SC_THRESH
) (
   input wire logic             clk,
   input wire logic             rst,
   simple_circuit_pipe_if.slave bus
);
   typedef struct packed {
      logic [WIDTH-1:0] and_out;
      logic [WIDTH-1:0] or_out;
      logic [WIDTH-1:0] inv_out;
      logic [WIDTH-1:0] c;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] e;
      logic [WIDTH-1:0] f;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] int1;
      logic [WIDTH-1:0] int2;
      logic [WIDTH-1:0] h;
   } s2_t;

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(THRESH);

   s1_t              w_s1_d;
   s1_t              w_s1_q;
   s2_t              w_s2_d;
   s2_t              w_s2_q;
   logic             w_s1_valid;
   logic             w_s2_ready;
   logic             w_count;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] r_rare_cnt;
   logic             r_alert;

   always_comb begin
      w_s1_d.and_out = bus.a & bus.b;
      w_s1_d.or_out  = bus.a | bus.c;
      w_s1_d.inv_out = ~bus.c;
      w_s1_d.c       = bus.c;
   end

   // Gate structure kept literal so int1/int2 stay visible to detection tools.
   always_comb begin
      w_s2_d.e    = w_s1_q.and_out;
      w_s2_d.f    = w_s1_q.or_out;
      w_s2_d.g    = w_s1_q.inv_out;
      w_s2_d.int1 = w_s1_q.or_out & w_s1_q.inv_out;
      w_s2_d.int2 = w_s1_q.and_out | w_s2_d.int1;
      w_s2_d.h    = w_s2_d.int2 & w_s1_q.c;
   end

   sc_pipe_slice #(.DW($bits(s1_t)), .RESET_DATA(1'b0)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (bus.in_valid),
      .o_ready (bus.in_ready),
      .i_data  (w_s1_d),
      .o_valid (w_s1_valid),
      .i_ready (w_s2_ready),
      .o_data  (w_s1_q)
   );

   sc_pipe_slice #(.DW($bits(s2_t)), .RESET_DATA(1'b1)) u_s2 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_s1_valid),
      .o_ready (w_s2_ready),
      .i_data  (w_s2_d),
      .o_valid (bus.out_valid),
      .i_ready (bus.out_ready),
      .o_data  (w_s2_q)
   );

   assign bus.e    = w_s2_q.e;
   assign bus.f    = w_s2_q.f;
   assign bus.g    = w_s2_q.g;
   assign bus.int1 = w_s2_q.int1;
   assign bus.int2 = w_s2_q.int2;
   assign bus.h    = w_s2_q.h;

   assign w_count = bus.out_valid && bus.out_ready && (|w_s2_q.h);

   // Clear takes priority over a counting transfer in the same cycle.
   always_comb begin
      w_cnt_next = r_rare_cnt;
      if (bus.clr_cnt) begin
         w_cnt_next = '0;
      end else if (w_count && (r_rare_cnt != c_CNT_MAX)) begin
         w_cnt_next = r_rare_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rare_cnt <= '0;
         r_alert    <= 1'b0;
      end else begin
         r_rare_cnt <= w_cnt_next;
         r_alert    <= (w_cnt_next >= c_THRESH);
      end
   end

   assign bus.rare_cnt = r_rare_cnt;
   assign bus.alert    = r_alert;
endmodule
`default_nettype wire

// File: tb/tb_simple_circuit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_circuit_pipe
// Brief    : Self-checking bench: vector table, scoreboard and counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_circuit_pipe;
   import simple_circuit_pkg::*;

   typedef struct packed {
      logic [7:0] e, f, g, i1, i2, h;
   } out_t;

   typedef struct packed {
      logic [7:0] a, b, c;
      out_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   simple_circuit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
   simple_circuit_pipe_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

   simple_circuit_pipe #(.WIDTH(8), .CNT_W(16), .THRESH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   simple_circuit_pipe #(.WIDTH(8), .CNT_W(2),  .THRESH(3)) dut_sat (.clk(clk), .rst(rst), .bus(bus2));

   assign bus2.a         = bus.a;
   assign bus2.b         = bus.b;
   assign bus2.c         = bus.c;
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.out_ready = bus.out_ready;
   assign bus2.clr_cnt   = bus.clr_cnt;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   out_t sb[$];
   out_t cur_exp;
   bit   rand_ready = 1'b0;
   vec_t tbl[6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Independent reference using the algebraically reduced forms.
   function automatic out_t ref_out(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      sc_s1_t s;
      out_t   o;
      s = '{and_out: a & b, or_out: a | c, inv_out: ~c, c: c};
      o.e  = s.and_out;
      o.f  = s.or_out;
      o.g  = s.inv_out;
      o.i1 = a & ~c;
      o.i2 = (a & b) | (a & ~c);
      o.h  = a & b & c;
      return o;
   endfunction

   // Scoreboard and counter model, sampled on the falling edge.
   logic [15:0] exp_cnt;
   logic [1:0]  exp_cnt2;
   logic        exp_alert, exp_alert2, have_prev, counted;
   out_t        prev, got, x;

   always @(negedge clk) begin
      got = '{bus.e, bus.f, bus.g, bus.int1, bus.int2, bus.h};
      if (rst) begin
         sb.delete();
         exp_cnt = '0; exp_cnt2 = '0; exp_alert = 1'b0; exp_alert2 = 1'b0; have_prev = 1'b0;
      end else begin
         check("rare_cnt", 64'(bus.rare_cnt), 64'(exp_cnt));
         check("alert", 64'(bus.alert), 64'(exp_alert));
         check("sat_cnt", 64'(bus2.rare_cnt), 64'(exp_cnt2));
         check("sat_alert", 64'(bus2.alert), 64'(exp_alert2));
         if (have_prev) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_data", 64'(got), 64'(prev));
         end
         have_prev = bus.out_valid && !bus.out_ready;
         prev      = got;
         counted   = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'(bus.out_valid), 64'd0);
            end else begin
               x = sb.pop_front();
               check("out_data", 64'(got), 64'(x));
               counted = |x.h;
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
         if (bus.clr_cnt) begin
            exp_cnt = '0; exp_cnt2 = '0;
         end else if (counted) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
         end
         exp_alert  = exp_cnt >= 16'd4;
         exp_alert2 = exp_cnt2 >= 2'd3;
      end
   end

   task automatic send(input vec_t v);
      logic acc;
      int   n;
      bus.a = v.a; bus.b = v.b; bus.c = v.c; cur_exp = v.exp; bus.in_valid = 1'b1;
      n = 0;
      do begin
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk); acc = bus.in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      bus.out_ready = 1'b1;
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_reset();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_efgh", {32'd0, bus.e, bus.f, bus.g, bus.h}, 64'd0);
      check("rst_cnt", 64'(bus.rare_cnt), 64'd0);
      check("rst_alert", 64'(bus.alert), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      vec_t v;
      int   idx, t0;
      logic acc;
      //            a      b      c        e      f      g      i1     i2     h
      tbl[0] = '{8'hF0, 8'hCC, 8'hAA, '{8'hC0, 8'hFA, 8'h55, 8'h50, 8'hD0, 8'h80}};
      tbl[1] = '{8'hFF, 8'hFF, 8'hFF, '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF}};
      tbl[2] = '{8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00}};
      tbl[3] = '{8'h0F, 8'h33, 8'h55, '{8'h03, 8'h5F, 8'hAA, 8'h0A, 8'h0B, 8'h01}};
      tbl[4] = '{8'hFF, 8'h00, 8'h0F, '{8'h00, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'h00}};
      tbl[5] = '{8'h3C, 8'hFF, 8'h00, '{8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C, 8'h00}};

      bus.a = '0; bus.b = '0; bus.c = '0; bus.in_valid = 1'b0;
      bus.out_ready = 1'b1; bus.clr_cnt = 1'b0; cur_exp = '0;
      repeat (2) @(posedge clk);
      #1 check_reset();
      rst = 1'b0;

      // Latency: accepted at edge 1, visible after edge 2.
      send(tbl[0]);
      check("lat_not_yet", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_valid", 64'(bus.out_valid), 64'd1);
      check("lat_efgh", {32'd0, bus.e, bus.f, bus.g, bus.h}, 64'hC0FA5580);
      drain();

      // Back-to-back table stream: one accept per cycle.
      t0 = cyc;
      for (int i = 0; i < 6; i++) send(tbl[i]);
      check("throughput", 64'(cyc - t0), 64'd6);
      drain();

      // Backpressure: 3 offered over 5 stalled cycles, only 2 fit.
      bus.out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 5; k++) begin
         v = tbl[idx];
         bus.a = v.a; bus.b = v.b; bus.c = v.c; cur_exp = v.exp; bus.in_valid = 1'b1;
         @(negedge clk); acc = bus.in_ready;
         @(posedge clk); #1;
         if (acc && idx < 2) idx++;
      end
      check("bp_accepted", 64'(idx), 64'd2);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      send(tbl[2]);
      drain();

      // Counter: 4 counted and 3 uncounted transfers.
      bus.clr_cnt = 1'b1; @(posedge clk); #1 bus.clr_cnt = 1'b0;
      send(tbl[0]); send(tbl[2]); send(tbl[1]); send(tbl[4]);
      send(tbl[3]); send(tbl[5]); send(tbl[1]);
      drain();
      @(posedge clk); #1;
      check("cnt_four", 64'(bus.rare_cnt), 64'd4);
      check("alert_set", 64'(bus.alert), 64'd1);
      send(tbl[3]);
      drain();
      @(posedge clk); #1;
      check("cnt_five", 64'(bus.rare_cnt), 64'd5);
      check("sat_no_wrap", 64'(bus2.rare_cnt), 64'd3);

      // Clear coinciding with a counted transfer.
      send(tbl[1]);
      while (!bus.out_valid && (cyc - t0) < 100000) begin @(posedge clk); #1; end
      bus.clr_cnt = 1'b1;
      @(posedge clk); #1 bus.clr_cnt = 1'b0;
      check("clr_cnt", 64'(bus.rare_cnt), 64'd0);
      check("clr_alert", 64'(bus.alert), 64'd0);
      check("clr_sat_cnt", 64'(bus2.rare_cnt), 64'd0);
      drain();

      // Random traffic with random backpressure against the reference.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         v.a = 8'($urandom); v.b = 8'($urandom); v.c = 8'($urandom);
         v.exp = ref_out(v.a, v.b, v.c);
         send(v);
      end
      rand_ready = 1'b0;
      drain();

      // Reset with data in flight: nothing may emerge afterwards.
      bus.out_ready = 1'b0;
      send(tbl[1]); send(tbl[0]);
      rst = 1'b1;
      @(posedge clk); #1 check_reset();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("post_rst_idle", 64'(bus.out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
